// File: rtl/parallel_serial_framer.sv
`default_nettype none
// ============================================================================
//  Module      : parallel_serial_framer
//  Description : Handshaked parallel-to-serial framer for the BPSK modulator
//                bit input. One-word holding buffer plus shift register, so
//                back-to-back words stream with no idle gap. Each bit is held
//                for SAMPLES_PER_BIT cycles.
//                Optional macro PARALLEL_SERIAL_PARITY_EN appends an even
//                parity bit (XOR of the data bits) after the data bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module parallel_serial_framer #(
    parameter int WIDTH           = 16,
    parameter int SAMPLES_PER_BIT = 1,
    parameter bit MSB_FIRST       = 1'b0,
    parameter bit IDLE_LEVEL      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] parallel_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             clear,
    output logic             serial_signal,
    output logic             bit_strobe,
    output logic             active,
    output logic             done
);

`ifdef PARALLEL_SERIAL_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BIT_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int SAMP_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLES_PER_BIT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  buf_data;
    logic              buf_full;
    logic [NBITS-1:0]  shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [SAMP_W-1:0] samp_cnt;

    logic              handshake;
    logic              last_sample;
    logic              word_end;
    logic              cur_bit;
    logic [NBITS-1:0]  frame;
    logic [NBITS-1:0]  shreg_next;

    // The buffer refuses words while full, during clear and while in reset.
    assign load_ready  = !buf_full && !clear && rst_n;
    assign handshake   = load_valid && load_ready;
    assign last_sample = (samp_cnt == SAMP_LAST);
    assign word_end    = last_sample && (bit_cnt == BIT_LAST);

    // Frame layout in the shift register: the bit to send first sits at the
    // end the register shifts out of; parity (if present) is always last.
    generate
        if (MSB_FIRST) begin : g_msb_first
`ifdef PARALLEL_SERIAL_PARITY_EN
            assign frame = {buf_data, ^buf_data};
`else
            assign frame = buf_data;
`endif
            assign cur_bit    = shreg[NBITS-1];
            assign shreg_next = {shreg[NBITS-2:0], 1'b0};
        end else begin : g_lsb_first
`ifdef PARALLEL_SERIAL_PARITY_EN
            assign frame = {^buf_data, buf_data};
`else
            assign frame = buf_data;
`endif
            assign cur_bit    = shreg[0];
            assign shreg_next = {1'b0, shreg[NBITS-1:1]};
        end
    endgenerate

    // Outputs are decoded purely from registered state.
    assign active        = (state == ST_SHIFT);
    assign serial_signal = active ? cur_bit : IDLE_LEVEL;
    assign bit_strobe    = active && (samp_cnt == '0);
    assign done          = active && word_end;

    // Buffer capture, word hand-over and bit/sample sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            buf_data <= '0;
            buf_full <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            samp_cnt <= '0;
        end else if (clear) begin
            state    <= ST_IDLE;
            buf_full <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            samp_cnt <= '0;
        end else begin
            // Capture only happens while the buffer is empty, so it never
            // collides with the buffer being drained below.
            if (handshake) begin
                buf_data <= parallel_data;
                buf_full <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (buf_full) begin
                        shreg    <= frame;
                        buf_full <= 1'b0;
                        bit_cnt  <= '0;
                        samp_cnt <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!last_sample) begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end else if (!word_end) begin
                        samp_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        shreg    <= shreg_next;
                    end else if (buf_full) begin
                        // Chain straight into the buffered word: no gap cycle.
                        shreg    <= frame;
                        buf_full <= 1'b0;
                        bit_cnt  <= '0;
                        samp_cnt <= '0;
                    end else begin
                        samp_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
